// File: rtl/dmem_arbiter.sv
// Two-port arbiter for one single-port data memory; port 0 has priority, port 1 is guaranteed a slot after MAX_BURST.
// Latency: grant one cycle after the request is sampled, read data MEM_LAT+2 cycles after it (all outputs registered).
// Backpressure: a request is held until its grant; DMEM_ARB_STATS_EN adds a conflict counter with synchronous clear.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic          stats_clr,
  output logic [15:0]   conflict_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
  localparam logic [2:0] LAT       = 3'(MEM_LAT);

  logic [1:0] state;
  logic       win;
  logic       is_wr;
  logic [2:0] lat_cnt;
  logic [3:0] burst_cnt;
  logic       any_req;
  logic       pick1;

  assign any_req = req0 | req1;
  // Port 1 wins when alone, or when port 0 has used up its burst allowance.
  assign pick1   = req1 & (~req0 | (burst_cnt == BURST_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      win       <= 1'b0;
      is_wr     <= 1'b0;
      lat_cnt   <= '0;
      burst_cnt <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (!req1 || pick1) begin
            burst_cnt <= '0;
          end else if (burst_cnt != BURST_MAX) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
          if (any_req) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            win       <= pick1;
            is_wr     <= pick1 ? we1 : we0;
            mem_en    <= 1'b1;
            mem_we    <= pick1 ? we1 : we0;
            mem_addr  <= pick1 ? addr1 : addr0;
            mem_wdata <= pick1 ? wdata1 : wdata0;
            gnt0      <= ~pick1;
            gnt1      <= pick1;
          end
        end
        ISSUE: begin
          if (is_wr) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= WAIT;
            lat_cnt <= LAT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          // Last wait cycle is the one in which the memory presents read data.
          if (lat_cnt == 3'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (win) begin
              rvalid1 <= 1'b1;
              rdata1  <= mem_rdata;
            end else begin
              rvalid0 <= 1'b1;
              rdata0  <= mem_rdata;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= '0;
    end else if (stats_clr) begin
      conflict_cnt <= '0;
    end else if (state == IDLE && req0 && req1 && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: a MEM_LAT=1 instance for most scenarios and a MEM_LAT=3 instance for the latency sweep.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;

  logic        gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  logic        b_req0, b_req1;
  logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata, b_mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] conflict_cnt, b_conflict_cnt;
`endif

  int npass = 0;
  int ntot  = 0;

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
`ifdef DMEM_ARB_STATS_EN
    , .stats_clr(stats_clr), .conflict_cnt(conflict_cnt)
`endif
  );

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_BURST(4)) dut3 (
    .clk(clk), .reset(reset),
    .req0(b_req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
    .req1(b_req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .busy(b_busy)
`ifdef DMEM_ARB_STATS_EN
    , .stats_clr(stats_clr), .conflict_cnt(b_conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only memory image: one known word at 0x40, address-derived data elsewhere.
  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  logic [31:0] p1;
  logic [31:0] q0, q1, q2;
  always @(posedge clk) begin
    p1 <= mem_en ? memval(mem_addr) : 32'h0;
    q0 <= b_mem_en ? memval(b_mem_addr) : 32'h0;
    q1 <= q0;
    q2 <= q1;
  end
  assign mem_rdata   = p1;
  assign b_mem_rdata = q2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    b_req0 = 0; b_req1 = 0;
`ifdef DMEM_ARB_STATS_EN
    stats_clr = 0;
`endif
    reset = 1;
    #1 reset = 0;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_b_busy", b_busy, 0);
`ifdef DMEM_ARB_STATS_EN
    chk("rst_conflict", conflict_cnt, 0);
`endif
    step(); step();
    reset = 1;
    step();

    // Port 0 read, MEM_LAT=1
    addr0 = 32'h40; we0 = 0; req0 = 1;
    step();
    chk("rd_gnt0", gnt0, 1);
    chk("rd_gnt1", gnt1, 0);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 32'h40);
    chk("rd_busy1", busy, 1);
    req0 = 0;
    step();
    chk("rd_gnt0_pulse", gnt0, 0);
    chk("rd_mem_en_off", mem_en, 0);
    chk("rd_mem_addr_off", mem_addr, 0);
    chk("rd_busy2", busy, 1);
    chk("rd_rvalid_early", rvalid0, 0);
    step();
    chk("rd_rvalid0", rvalid0, 1);
    chk("rd_rdata0", rdata0, 32'hDEADBEEF);
    chk("rd_busy3", busy, 0);
    step();
    chk("rd_rvalid0_pulse", rvalid0, 0);
    chk("rd_rdata0_hold", rdata0, 32'hDEADBEEF);

    // Port 1 write
    we1 = 1; addr1 = 32'h54; wdata1 = 32'h7; req1 = 1;
    step();
    chk("wr_gnt1", gnt1, 1);
    chk("wr_gnt0", gnt0, 0);
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 32'h54);
    chk("wr_mem_wdata", mem_wdata, 32'h7);
    req1 = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wr_no_rvalid1", rvalid1, 0);
      chk("wr_mem_en_off", mem_en, 0);
    end
    chk("wr_busy_idle", busy, 0);
    chk("wr_rdata1", rdata1, 0);

    // Simultaneous write requests, burst limit 4
    we0 = 1; addr0 = 32'h100; wdata0 = 32'hAA;
    we1 = 1; addr1 = 32'h200; wdata1 = 32'hBB;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("burst_gnt0", gnt0, (i % 5 != 4));
      chk("burst_gnt1", gnt1, (i % 5 == 4));
      chk("burst_addr", mem_addr, (i % 5 == 4) ? 32'h200 : 32'h100);
      if (i == 9) req1 = 0;
      step();
    end
    step();
    chk("burst_drain_gnt0", gnt0, 1);
    req0 = 0;
    step();

    // Reset during WAIT
    we0 = 0; addr0 = 32'h44; req0 = 1;
    step();
    chk("rstw_gnt0", gnt0, 1);
    req0 = 0;
    step();
    chk("rstw_busy_wait", busy, 1);
    reset = 0;
    #1;
    chk("rstw_rvalid0", rvalid0, 0);
    chk("rstw_rdata0", rdata0, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_mem_en", mem_en, 0);
    step(); step();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstw_no_rvalid0", rvalid0, 0);
      chk("rstw_idle", busy, 0);
    end
    addr0 = 32'h40; req0 = 1;
    step();
    chk("rstw_regnt0", gnt0, 1);
    req0 = 0;
    step(); step();
    chk("rstw_rvalid0_new", rvalid0, 1);
    chk("rstw_rdata0_new", rdata0, 32'hDEADBEEF);

    // Latency sweep, MEM_LAT=3
    addr0 = 32'h80; we0 = 0; b_req0 = 1;
    step();
    chk("lat_gnt0", b_gnt0, 1);
    chk("lat_mem_addr", b_mem_addr, 32'h80);
    b_req0 = 0;
    step();
    chk("lat_busy", b_busy, 1);
    we1 = 1; addr1 = 32'h10; wdata1 = 32'h33; b_req1 = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("lat_no_rvalid", b_rvalid0, 0);
      chk("lat_no_gnt1", b_gnt1, 0);
    end
    step();
    chk("lat_rvalid0", b_rvalid0, 1);
    chk("lat_rdata0", b_rdata0, 32'h5A5A0080);
    chk("lat_gnt1_held", b_gnt1, 0);
    chk("lat_busy_idle", b_busy, 0);
    step();
    chk("lat_gnt1", b_gnt1, 1);
    chk("lat_mem_we", b_mem_we, 1);
    chk("lat_mem_wdata", b_mem_wdata, 32'h33);
    chk("lat_rvalid_pulse", b_rvalid0, 0);
    chk("lat_no_rvalid1", b_rvalid1, 0);
    chk("lat_rdata1", b_rdata1, 0);
    b_req1 = 0;
    step(); step();

`ifdef DMEM_ARB_STATS_EN
    // Conflict counter over 6 IDLE cycles with both ports requesting
    stats_clr = 1;
    step();
    stats_clr = 0;
    chk("stats_clr0", conflict_cnt, 0);
    we0 = 1; we1 = 1; addr0 = 32'h8; addr1 = 32'hC;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 5; i++) begin
      step(); step();
    end
    step();
    chk("stats_six", conflict_cnt, 6);
    if (gnt0) req0 = 0;
    else req1 = 0;
    step(); step();
    req0 = 0; req1 = 0;
    chk("stats_six_hold", conflict_cnt, 6);
    chk("stats_b_zero", b_conflict_cnt, 0);
    stats_clr = 1;
    step();
    stats_clr = 0;
    chk("stats_clr", conflict_cnt, 0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
